// File: rtl/acq_seq_pkg.sv
// Shared definitions for the acquisition run sequencer: state encodings,
// the latched run-configuration record and parameter defaults.
package acq_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ARM   = ST_ARM,
    RUN   = ST_RUN,
    GAP   = ST_GAP,
    DONE  = ST_DONE,
    ERROR = ST_ERROR
  } state_t;

  localparam int ARM_CYCLES_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 2000000;
  localparam int CFG_GAP_W          = 32;

  typedef struct packed {
    logic                 raw_mode;
    logic [15:0]          num_packets;
    logic [15:0]          num_bursts;
    logic [CFG_GAP_W-1:0] burst_gap;
  } acq_cfg_t;

endpackage

// File: rtl/acq_seq_down_counter.sv
// Loadable down-counter with a zero flag; load has priority over decrement
// and the count holds at zero.
module acq_seq_down_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/acq_sequencer.sv
// Run-control sequencer for sensor_data_acquisition: arms, runs, gaps and stops
// the datapath. Optional stream watchdog enabled by defining ACQ_SEQ_WATCHDOG_EN.
module acq_sequencer
  import acq_seq_pkg::*;
#(
  parameter int ARM_CYCLES     = ARM_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int GAP_W          = CFG_GAP_W
) (
  input  logic             master_clock,
  input  logic             resetn,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_raw_mode,
  input  logic [15:0]      cmd_num_packets,
  input  logic [15:0]      cmd_num_bursts,
  input  logic [GAP_W-1:0] cmd_burst_gap,
  input  logic             mon_tvalid,
  input  logic             mon_tready,
  input  logic             mon_tlast,
  output logic             acq_resetn,
  output logic             acq_send_raw_data,
  output logic [15:0]      acq_number_of_packet,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [15:0]      burst_count,
  output logic [2:0]       dbg_state
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t               state;
  state_t               next_state;
  acq_cfg_t             cfg;
  logic                 stop_pending;
  logic                 beat;
  logic                 eob;
  logic                 start_ok;
  logic                 last_burst;
  logic [15:0]          count_inc;
  logic                 timer_load;
  logic [CFG_GAP_W-1:0] timer_val;
  logic                 timer_dec;
  logic                 timer_zero;
  logic                 timeout;

  assign beat       = mon_tvalid & mon_tready;
  assign eob        = beat & mon_tlast;
  assign start_ok   = (state == IDLE) && cmd_start && !cmd_stop;
  assign count_inc  = sat_inc16(burst_count);
  // A stop arriving together with tlast still ends the run after that burst.
  assign last_burst = stop_pending || cmd_stop ||
                      ((cfg.num_bursts != 16'd0) && (count_inc == cfg.num_bursts));
  assign timer_dec  = (state == ARM) || (state == GAP);

  acq_seq_down_counter #(.W(CFG_GAP_W)) u_timer (
    .clk      (master_clock),
    .rst_n    (resetn),
    .load     (timer_load),
    .load_val (timer_val),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

`ifdef ACQ_SEQ_WATCHDOG_EN
  localparam int             WD_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_RELOAD = WD_W'(TIMEOUT_CYCLES - 1);

  logic wd_load;
  logic wd_dec;
  logic wd_zero;

  // Held at reload outside RUN, so RUN entry always starts a fresh window.
  assign wd_load = (state != RUN) || beat;
  assign wd_dec  = (state == RUN) && !beat;
  assign timeout = (state == RUN) && !beat && wd_zero;

  acq_seq_down_counter #(.W(WD_W)) u_watchdog (
    .clk      (master_clock),
    .rst_n    (resetn),
    .load     (wd_load),
    .load_val (WD_RELOAD),
    .dec      (wd_dec),
    .zero     (wd_zero)
  );

  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      timeout_err <= 1'b0;
    end else if (start_ok) begin
      timeout_err <= 1'b0;
    end else if (next_state == ERROR) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign timeout     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          next_state = ARM;
          timer_load = 1'b1;
          timer_val  = CFG_GAP_W'(ARM_CYCLES - 1);
        end
      end
      ARM: begin
        if (cmd_stop) begin
          next_state = DONE;
        end else if (timer_zero) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (eob) begin
          if (last_burst) begin
            next_state = DONE;
          end else if (cfg.burst_gap != '0) begin
            next_state = GAP;
            timer_load = 1'b1;
            timer_val  = cfg.burst_gap - CFG_GAP_W'(1);
          end
        end else if (timeout) begin
          next_state = ERROR;
        end
      end
      GAP: begin
        if (cmd_stop) begin
          next_state = DONE;
        end else if (timer_zero) begin
          next_state = RUN;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      ERROR: begin
        if (cmd_stop) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Outputs are registered from next_state so they line up with the state register.
  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      acq_resetn   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      dbg_state    <= ST_IDLE;
      burst_count  <= 16'd0;
      stop_pending <= 1'b0;
      cfg          <= '0;
    end else begin
      acq_resetn <= (next_state == RUN);
      busy       <= (next_state != IDLE);
      done       <= (next_state == DONE);
      dbg_state  <= next_state;

      if (start_ok) begin
        cfg.raw_mode    <= cmd_raw_mode;
        cfg.num_packets <= cmd_num_packets;
        cfg.num_bursts  <= cmd_num_bursts;
        cfg.burst_gap   <= CFG_GAP_W'(cmd_burst_gap);
        burst_count     <= 16'd0;
      end else if ((state == RUN) && eob) begin
        burst_count <= count_inc;
      end

      if (state == IDLE) begin
        stop_pending <= 1'b0;
      end else if ((state == RUN) && cmd_stop) begin
        stop_pending <= 1'b1;
      end
    end
  end

  assign acq_send_raw_data    = cfg.raw_mode;
  assign acq_number_of_packet = cfg.num_packets;

endmodule

// File: tb/tb_acq_sequencer.sv
// Randomized self-checking bench for acq_sequencer; expectations come from the
// run rules (burst totals, arm/gap lengths, stop behaviour), not the RTL structure.
module tb_acq_sequencer;

  localparam int ARM_C = 4;
  localparam int TMO   = 50;
  localparam int GW    = 32;

  logic          master_clock = 1'b0;
  logic          resetn;
  logic          cmd_start;
  logic          cmd_stop;
  logic          cmd_raw_mode;
  logic [15:0]   cmd_num_packets;
  logic [15:0]   cmd_num_bursts;
  logic [GW-1:0] cmd_burst_gap;
  logic          mon_tvalid;
  logic          mon_tready;
  logic          mon_tlast;
  logic          acq_resetn;
  logic          acq_send_raw_data;
  logic [15:0]   acq_number_of_packet;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [15:0]   burst_count;
  logic [2:0]    dbg_state;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always #5 master_clock = ~master_clock;

  always @(negedge master_clock) if (done === 1'b1) done_cnt++;

  acq_sequencer #(
    .ARM_CYCLES     (ARM_C),
    .TIMEOUT_CYCLES (TMO),
    .GAP_W          (GW)
  ) dut (
    .master_clock         (master_clock),
    .resetn               (resetn),
    .cmd_start            (cmd_start),
    .cmd_stop             (cmd_stop),
    .cmd_raw_mode         (cmd_raw_mode),
    .cmd_num_packets      (cmd_num_packets),
    .cmd_num_bursts       (cmd_num_bursts),
    .cmd_burst_gap        (cmd_burst_gap),
    .mon_tvalid           (mon_tvalid),
    .mon_tready           (mon_tready),
    .mon_tlast            (mon_tlast),
    .acq_resetn           (acq_resetn),
    .acq_send_raw_data    (acq_send_raw_data),
    .acq_number_of_packet (acq_number_of_packet),
    .busy                 (busy),
    .done                 (done),
    .timeout_err          (timeout_err),
    .burst_count          (burst_count),
    .dbg_state            (dbg_state)
  );

  task automatic tick;
    @(posedge master_clock);
    #1;
  endtask

  task automatic drive_idle;
    cmd_start       = 1'b0;
    cmd_stop        = 1'b0;
    cmd_raw_mode    = 1'b0;
    cmd_num_packets = 16'd0;
    cmd_num_bursts  = 16'd0;
    cmd_burst_gap   = '0;
    mon_tvalid      = 1'b0;
    mon_tready      = 1'b0;
    mon_tlast       = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    drive_idle();
    repeat (3) tick();
    n_tests++;
    if ({acq_resetn, busy, done, timeout_err, acq_send_raw_data} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000",
               {acq_resetn, busy, done, timeout_err, acq_send_raw_data});
    end
    n_tests++;
    if ({burst_count, acq_number_of_packet, dbg_state} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_values: got cnt=%0d npk=%0d st=%0d want 0 0 0",
               burst_count, acq_number_of_packet, dbg_state);
    end
    resetn = 1'b1;
    repeat (2) tick();
    n_tests++;
    if ({busy, acq_resetn, dbg_state} !== 5'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b want 00000", {busy, acq_resetn, dbg_state});
    end
  endtask

  task automatic test_start_stop_same;
    cmd_start = 1'b1; cmd_stop = 1'b1;
    cmd_raw_mode = 1'b1; cmd_num_packets = 16'h1234; cmd_num_bursts = 16'd2; cmd_burst_gap = 5;
    tick();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({busy, acq_resetn, dbg_state, acq_send_raw_data} !== 6'b0) begin
        n_fail++;
        $display("FAIL start_stop_same: got %b want 000000",
                 {busy, acq_resetn, dbg_state, acq_send_raw_data});
      end
      tick();
    end
  endtask

  // mode: 0 run to num_bursts, 1 stop mid-burst k, 2 stop on tlast of burst k,
  // 3 stop during the gap after burst k.
  task automatic run_session(input string name, input bit raw, input logic [15:0] npk,
                             input logic [15:0] nb, input int gap, input int blen,
                             input int mode, input int k);
    int beats, exp_cnt, low, d0, exp_final;
    bit ended, stop_sent, v, r, l, s;
    d0 = done_cnt;
    exp_final = (mode == 0) ? int'(nb) : k;
    cmd_raw_mode = raw; cmd_num_packets = npk; cmd_num_bursts = nb; cmd_burst_gap = gap;
    cmd_start = 1'b1;
    tick();
    cmd_start       = 1'b0;
    cmd_raw_mode    = 1'($urandom);
    cmd_num_packets = 16'($urandom);
    cmd_num_bursts  = 16'($urandom);
    cmd_burst_gap   = $urandom;
    n_tests++;
    if ({busy, acq_resetn, dbg_state, burst_count} !== {1'b1, 1'b0, 3'd1, 16'd0}) begin
      n_fail++;
      $display("FAIL %s arm_entry: got busy=%b rn=%b st=%0d cnt=%0d want 1 0 1 0",
               name, busy, acq_resetn, dbg_state, burst_count);
    end
    low = 1;
    for (int c = 0; c < 100 && !acq_resetn; c++) begin
      tick();
      if (!acq_resetn) low++;
    end
    n_tests++;
    if (low !== ARM_C) begin
      n_fail++;
      $display("FAIL %s arm_len: got %0d want %0d", name, low, ARM_C);
    end
    beats = 0; exp_cnt = 0; ended = 0; stop_sent = 0;
    for (int cyc = 0; cyc < 20000 && !ended; cyc++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      l = (beats == blen - 1);
      s = 1'b0;
      if (mode == 1 && !stop_sent && exp_cnt == k - 1 && beats == 1) begin
        s = 1'b1; stop_sent = 1'b1;
      end
      if (mode == 2 && !stop_sent && exp_cnt == k - 1 && l) begin
        v = 1'b1; r = 1'b1; s = 1'b1; stop_sent = 1'b1;
      end
      mon_tvalid = v; mon_tready = r; mon_tlast = l; cmd_stop = s;
      tick();
      cmd_stop = 1'b0; mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
      if (v && r && l) begin
        exp_cnt++;
        beats = 0;
        n_tests++;
        if (burst_count !== 16'(exp_cnt)) begin
          n_fail++;
          $display("FAIL %s burst_count: got %0d want %0d", name, burst_count, exp_cnt);
        end
        if (stop_sent || (nb != 0 && exp_cnt == int'(nb))) begin
          n_tests++;
          if ({done, acq_resetn, dbg_state} !== {1'b1, 1'b0, 3'd4}) begin
            n_fail++;
            $display("FAIL %s done_state: got done=%b rn=%b st=%0d want 1 0 4",
                     name, done, acq_resetn, dbg_state);
          end
          tick();
          n_tests++;
          if ({busy, done, dbg_state} !== 5'b0) begin
            n_fail++;
            $display("FAIL %s back_to_idle: got %b want 00000", name, {busy, done, dbg_state});
          end
          ended = 1'b1;
        end else if (gap == 0) begin
          n_tests++;
          if ({acq_resetn, dbg_state} !== {1'b1, 3'd2}) begin
            n_fail++;
            $display("FAIL %s stay_run: got rn=%b st=%0d want 1 2", name, acq_resetn, dbg_state);
          end
        end else begin
          low = 1;
          for (int g = 0; g < gap + 10 && !acq_resetn && !ended; g++) begin
            if (mode == 3 && exp_cnt == k && low == 2) begin
              cmd_stop = 1'b1;
              tick();
              cmd_stop = 1'b0;
              n_tests++;
              if ({done, acq_resetn, dbg_state, burst_count} !== {1'b1, 1'b0, 3'd4, 16'(exp_cnt)}) begin
                n_fail++;
                $display("FAIL %s gap_stop: got done=%b rn=%b st=%0d cnt=%0d want 1 0 4 %0d",
                         name, done, acq_resetn, dbg_state, burst_count, exp_cnt);
              end
              tick();
              ended = 1'b1;
            end else begin
              tick();
              if (!acq_resetn) low++;
            end
          end
          if (!ended) begin
            n_tests++;
            if (low !== gap) begin
              n_fail++;
              $display("FAIL %s gap_len: got %0d want %0d", name, low, gap);
            end
          end
        end
      end else begin
        if (v && r) beats++;
        if (s) begin
          n_tests++;
          if (dbg_state !== 3'd2) begin
            n_fail++;
            $display("FAIL %s graceful_stop: got st=%0d want 2", name, dbg_state);
          end
        end
      end
    end
    n_tests++;
    if (!ended) begin
      n_fail++;
      $display("FAIL %s run_end: got no end within budget want done", name);
    end
    n_tests++;
    if (done_cnt !== d0 + 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - d0);
    end
    n_tests++;
    if ({busy, burst_count} !== {1'b0, 16'(exp_final)}) begin
      n_fail++;
      $display("FAIL %s final_count: got busy=%b cnt=%0d want 0 %0d",
               name, busy, burst_count, exp_final);
    end
    n_tests++;
    if ({acq_send_raw_data, acq_number_of_packet} !== {raw, npk}) begin
      n_fail++;
      $display("FAIL %s config_hold: got raw=%b npk=%0d want %b %0d",
               name, acq_send_raw_data, acq_number_of_packet, raw, npk);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_random_runs;
    for (int it = 0; it < 6; it++) begin
      int nb, gap, blen, mode, k;
      nb   = $urandom_range(0, 4);
      gap  = $urandom_range(0, 12);
      blen = $urandom_range(3, 12);
      mode = $urandom_range(0, 3);
      k    = 1;
      if (mode == 3 && gap < 3) mode = 2;
      if (mode == 0 && nb == 0) mode = 1;
      if (mode == 3) begin
        if (nb == 1) nb = 2;
        k = (nb == 0) ? $urandom_range(1, 3) : $urandom_range(1, nb - 1);
      end else if (mode != 0) begin
        k = (nb == 0) ? $urandom_range(1, 3) : $urandom_range(1, nb);
      end
      run_session("rnd", 1'($urandom), 16'($urandom), 16'(nb), gap, blen, mode, k);
    end
  endtask

  task automatic test_watchdog;
    int n;
    cmd_num_bursts = 16'd1; cmd_burst_gap = 0; cmd_num_packets = 16'd7;
    cmd_start = 1'b1;
    tick();
    drive_idle();
    for (int c = 0; c < 20 && !acq_resetn; c++) tick();
    n = 1;
    for (int c = 0; c < 300 && dbg_state == 3'd2; c++) begin
      tick();
      if (dbg_state == 3'd2) n++;
    end
`ifdef ACQ_SEQ_WATCHDOG_EN
    n_tests++;
    if (n !== TMO) begin
      n_fail++;
      $display("FAIL wd_run_len: got %0d want %0d", n, TMO);
    end
    n_tests++;
    if ({dbg_state, timeout_err, acq_resetn, busy} !== {3'd5, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL wd_error: got st=%0d err=%b rn=%b busy=%b want 5 1 0 1",
               dbg_state, timeout_err, acq_resetn, busy);
    end
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    n_tests++;
    if ({busy, dbg_state, timeout_err} !== {1'b0, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL wd_sticky: got busy=%b st=%0d err=%b want 0 0 1", busy, dbg_state, timeout_err);
    end
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    n_tests++;
    if ({timeout_err, dbg_state} !== {1'b0, 3'd1}) begin
      n_fail++;
      $display("FAIL wd_clear: got err=%b st=%0d want 0 1", timeout_err, dbg_state);
    end
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    tick();
`else
    n_tests++;
    if ({dbg_state, timeout_err, acq_resetn} !== {3'd2, 1'b0, 1'b1} || n < 300) begin
      n_fail++;
      $display("FAIL nowd_wait: got st=%0d err=%b rn=%b run=%0d want 2 0 1 >=300",
               dbg_state, timeout_err, acq_resetn, n);
    end
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
    tick();
    drive_idle();
    n_tests++;
    if ({done, dbg_state, burst_count} !== {1'b1, 3'd4, 16'd1}) begin
      n_fail++;
      $display("FAIL nowd_stop: got done=%b st=%0d cnt=%0d want 1 4 1", done, dbg_state, burst_count);
    end
    tick();
`endif
  endtask

  task automatic test_arm_stop;
    cmd_num_bursts = 16'd3; cmd_start = 1'b1;
    tick();
    drive_idle();
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    n_tests++;
    if ({done, acq_resetn, dbg_state} !== {1'b1, 1'b0, 3'd4}) begin
      n_fail++;
      $display("FAIL arm_stop: got done=%b rn=%b st=%0d want 1 0 4", done, acq_resetn, dbg_state);
    end
    tick();
    n_tests++;
    if ({busy, dbg_state} !== 4'b0) begin
      n_fail++;
      $display("FAIL arm_stop_idle: got busy=%b st=%0d want 0 0", busy, dbg_state);
    end
  endtask

  task automatic test_reset_mid_run;
    int d0;
    cmd_raw_mode = 1'b1; cmd_num_packets = 16'hA5A5; cmd_num_bursts = 16'd0; cmd_burst_gap = 0;
    cmd_start = 1'b1;
    tick();
    drive_idle();
    for (int c = 0; c < 20 && !acq_resetn; c++) tick();
    for (int i = 0; i < 5; i++) begin
      mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = (i == 4);
      tick();
    end
    drive_idle();
    n_tests++;
    if ({burst_count, dbg_state, acq_resetn} !== {16'd1, 3'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL pre_reset: got cnt=%0d st=%0d rn=%b want 1 2 1", burst_count, dbg_state, acq_resetn);
    end
    d0 = done_cnt;
    #2 resetn = 1'b0;
    #1;
    n_tests++;
    if ({acq_resetn, busy, done, timeout_err, acq_send_raw_data, burst_count,
         acq_number_of_packet, dbg_state} !== 40'd0) begin
      n_fail++;
      $display("FAIL async_reset: got rn=%b busy=%b raw=%b cnt=%0d npk=%0d st=%0d want all 0",
               acq_resetn, busy, acq_send_raw_data, burst_count, acq_number_of_packet, dbg_state);
    end
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    n_tests++;
    if (done_cnt !== d0 || dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_no_done: got pulses=%0d st=%0d want 0 0", done_cnt - d0, dbg_state);
    end
  endtask

  initial begin
    test_reset();
    test_start_stop_same();
    run_session("raw3", 1'b1, 16'($urandom), 16'd3, 0, 40, 0, 0);
    run_session("gap100", 1'b0, 16'($urandom), 16'd2, 100, 20, 0, 0);
    run_session("stop5", 1'b0, 16'($urandom), 16'd0, 0, 30, 1, 5);
    test_random_runs();
    test_watchdog();
    test_arm_stop();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
